// File: rtl/bounce_pkg.sv
// bounce_pkg: shared definitions for the bouncing-sprite motion engine.
//   - default display geometry and sprite size
//   - per-object state struct (obj_state_t)
//   - sweep FSM state type (fsm_state_t)
//   - LFSR seed/taps for the optional speed jitter
// Optional feature macro: BOUNCE_JITTER_EN (adds per-axis speed fields and
// LFSR constants).
package bounce_pkg;

  localparam int COORD_W      = 10;
  localparam int DISP_W_DEF   = 640;
  localparam int DISP_H_DEF   = 480;
  localparam int OBJ_SIZE_DEF = 128;

`ifdef BOUNCE_JITTER_EN
  // Speed range is 1..4, so three bits are enough.
  localparam int SPD_W = 3;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 (1-based) -> bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
`endif

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } fsm_state_t;

  // dir_x: 1 = moving right; dir_y: 1 = moving down.
  typedef struct packed {
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] top;
    logic               dir_x;
    logic               dir_y;
    logic [2:0]         color;
`ifdef BOUNCE_JITTER_EN
    logic [SPD_W-1:0]   sx;
    logic [SPD_W-1:0]   sy;
`endif
  } obj_state_t;

endpackage

// File: rtl/bounce_motion_engine_if.sv
// bounce_motion_engine_if: groups the frame-control and pixel-query signals
// of the motion engine.
//   master (screensaver top side): drives frame_start, pause, pix_x, pix_y;
//                                  receives pixel results, busy, bounce.
//   slave  (motion engine):        the reverse.
// Signalling: there is no valid/ready pair. frame_start is a single-cycle
// request pulse that is accepted only when the engine is idle and pause is
// low; otherwise it is dropped, never queued. busy is high for exactly
// NUM_OBJ cycles per accepted request. pix_x/pix_y are sampled every cycle
// and the pixel results appear one cycle later.
interface bounce_motion_engine_if #(
  parameter int NUM_OBJ  = 4,
  parameter int OBJ_SIZE = 128,
  parameter int COORD_W  = 10
);
  localparam int ID_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int L_W  = $clog2(OBJ_SIZE);

  logic               frame_start;
  logic               pause;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               obj_hit;
  logic [ID_W-1:0]    obj_id;
  logic [L_W-1:0]     obj_lx;
  logic [L_W-1:0]     obj_ly;
  logic [2:0]         obj_color;
  logic               busy;
  logic [NUM_OBJ-1:0] bounce;

  modport master (
    output frame_start, pause, pix_x, pix_y,
    input  obj_hit, obj_id, obj_lx, obj_ly, obj_color, busy, bounce
  );

  modport slave (
    input  frame_start, pause, pix_x, pix_y,
    output obj_hit, obj_id, obj_lx, obj_ly, obj_color, busy, bounce
  );
endinterface

// File: rtl/bounce_obj_step.sv
// bounce_obj_step: combinational one-frame move of a single object on both
// axes, with wall clamping, direction reversal and colour stepping.
// Ports:
//   cur     in   current object state
//   step_x  in   px to move along x this frame
//   step_y  in   px to move along y this frame
//   rnd     in   2 random bits for the new speed (BOUNCE_JITTER_EN only)
//   nxt     out  object state after the move
//   bounce  out  1 if either axis hit a wall
// Optional feature macro: BOUNCE_JITTER_EN.
module bounce_obj_step
  import bounce_pkg::*;
#(
  parameter int DISP_W   = DISP_W_DEF,
  parameter int DISP_H   = DISP_H_DEF,
  parameter int OBJ_SIZE = OBJ_SIZE_DEF
) (
  input  obj_state_t         cur,
  input  logic [COORD_W-1:0] step_x,
  input  logic [COORD_W-1:0] step_y,
`ifdef BOUNCE_JITTER_EN
  input  logic [1:0]         rnd,
`endif
  output obj_state_t         nxt,
  output logic               bounce
);
  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(DISP_W - OBJ_SIZE);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(DISP_H - OBJ_SIZE);

  // One extra bit so left+step cannot wrap before the wall compare.
  logic [COORD_W:0] sum_x;
  logic [COORD_W:0] sum_y;
  logic             bx;
  logic             by;

  assign sum_x = {1'b0, cur.left} + {1'b0, step_x};
  assign sum_y = {1'b0, cur.top}  + {1'b0, step_y};

  always_comb begin
    nxt = cur;
    bx  = 1'b0;
    by  = 1'b0;

    if (!cur.dir_x) begin
      if (cur.left <= step_x) begin
        nxt.left  = '0;
        nxt.dir_x = 1'b1;
        bx        = 1'b1;
      end else begin
        nxt.left = cur.left - step_x;
      end
    end else begin
      if (sum_x >= {1'b0, MAX_X}) begin
        nxt.left  = MAX_X;
        nxt.dir_x = 1'b0;
        bx        = 1'b1;
      end else begin
        nxt.left = sum_x[COORD_W-1:0];
      end
    end

    if (!cur.dir_y) begin
      if (cur.top <= step_y) begin
        nxt.top   = '0;
        nxt.dir_y = 1'b1;
        by        = 1'b1;
      end else begin
        nxt.top = cur.top - step_y;
      end
    end else begin
      if (sum_y >= {1'b0, MAX_Y}) begin
        nxt.top   = MAX_Y;
        nxt.dir_y = 1'b0;
        by        = 1'b1;
      end else begin
        nxt.top = sum_y[COORD_W-1:0];
      end
    end

    // A corner hit steps the colour only once.
    if (bx || by) begin
      nxt.color = cur.color + 3'd1;
    end

`ifdef BOUNCE_JITTER_EN
    if (bx) nxt.sx = SPD_W'(rnd) + SPD_W'(1);
    if (by) nxt.sy = SPD_W'(rnd) + SPD_W'(1);
`endif
  end

  assign bounce = bx | by;

endmodule

// File: rtl/bounce_motion_engine.sv
// bounce_motion_engine: moves NUM_OBJ square sprites that bounce off the
// display edges once per frame, and reports per pixel which sprite covers
// the beam position.
// Ports:
//   clk        in   pixel clock
//   reset      in   synchronous, active-high reset
//   bus        slave modport of bounce_motion_engine_if:
//                frame_start/pause in, pix_x/pix_y in,
//                obj_hit/obj_id/obj_lx/obj_ly/obj_color out (latency 1),
//                busy out (update sweep running), bounce out (per-object pulse)
//   dbg_state  out  current sweep FSM state
// Coordinate width is bounce_pkg::COORD_W.
// Optional feature macro: BOUNCE_JITTER_EN (LFSR-driven speed change on
// every wall bounce).
module bounce_motion_engine
  import bounce_pkg::*;
#(
  parameter int NUM_OBJ  = 4,
  parameter int OBJ_SIZE = OBJ_SIZE_DEF,
  parameter int DISP_W   = DISP_W_DEF,
  parameter int DISP_H   = DISP_H_DEF,
  parameter int STEP     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bounce_motion_engine_if.slave bus,
  output fsm_state_t            dbg_state
);
  localparam int ID_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int L_W  = $clog2(OBJ_SIZE);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_OBJ - 1);

  obj_state_t         objs [NUM_OBJ];
  obj_state_t         cur_obj;
  obj_state_t         nxt_obj;
  logic               step_bounce;
  logic [COORD_W-1:0] step_x;
  logic [COORD_W-1:0] step_y;

  fsm_state_t         state;
  logic [ID_W-1:0]    idx;
  logic               busy_q;
  logic [NUM_OBJ-1:0] bounce_q;

  function automatic obj_state_t reset_obj(input int i);
    obj_state_t o;
    o       = '0;
    o.left  = COORD_W'((200 + 37 * i) % (DISP_W - OBJ_SIZE));
    o.top   = COORD_W'((200 + 53 * i) % (DISP_H - OBJ_SIZE));
    o.dir_x = 1'b1;
    o.dir_y = i[0];
    o.color = 3'(i % 8);
`ifdef BOUNCE_JITTER_EN
    o.sx    = SPD_W'(STEP);
    o.sy    = SPD_W'(STEP);
`endif
    return o;
  endfunction

  // A single step unit is shared by all objects; the sweep feeds it one
  // object per cycle.
  assign cur_obj = objs[idx];

`ifdef BOUNCE_JITTER_EN
  logic [7:0] lfsr;

  assign step_x = COORD_W'(cur_obj.sx);
  assign step_y = COORD_W'(cur_obj.sy);

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end
`else
  assign step_x = COORD_W'(STEP);
  assign step_y = COORD_W'(STEP);
`endif

  bounce_obj_step #(
    .DISP_W   (DISP_W),
    .DISP_H   (DISP_H),
    .OBJ_SIZE (OBJ_SIZE)
  ) u_step (
    .cur    (cur_obj),
    .step_x (step_x),
    .step_y (step_y),
`ifdef BOUNCE_JITTER_EN
    .rnd    (lfsr[1:0]),
`endif
    .nxt    (nxt_obj),
    .bounce (step_bounce)
  );

  // Sweep FSM. busy mirrors the UPDATE state so it is high for exactly
  // NUM_OBJ cycles; bounce for an object lands one cycle after its update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      busy_q   <= 1'b0;
      bounce_q <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        objs[i] <= reset_obj(i);
      end
    end else begin
      bounce_q <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.frame_start && !bus.pause) begin
            state  <= ST_UPDATE;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_UPDATE: begin
          objs[idx]     <= nxt_obj;
          bounce_q[idx] <= step_bounce;
          if (idx == LAST_IDX) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            idx <= idx + ID_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Pixel path. Offsets wrap modulo 2^COORD_W, so a beam left of / above an
  // object yields a large offset and fails the size compare. Scanning from
  // the highest index down lets the lowest covering index win.
  logic               hit_c;
  logic [ID_W-1:0]    id_c;
  logic [L_W-1:0]     lx_c;
  logic [L_W-1:0]     ly_c;
  logic [2:0]         col_c;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;

  always_comb begin
    hit_c = 1'b0;
    id_c  = '0;
    lx_c  = '0;
    ly_c  = '0;
    col_c = '0;
    dx    = '0;
    dy    = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      dx = bus.pix_x - objs[i].left;
      dy = bus.pix_y - objs[i].top;
      if (dx < COORD_W'(OBJ_SIZE) && dy < COORD_W'(OBJ_SIZE)) begin
        hit_c = 1'b1;
        id_c  = ID_W'(i);
        lx_c  = dx[L_W-1:0];
        ly_c  = dy[L_W-1:0];
        col_c = objs[i].color;
      end
    end
  end

  logic            hit_q;
  logic [ID_W-1:0] id_q;
  logic [L_W-1:0]  lx_q;
  logic [L_W-1:0]  ly_q;
  logic [2:0]      col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
      id_q  <= '0;
      lx_q  <= '0;
      ly_q  <= '0;
      col_q <= '0;
    end else begin
      hit_q <= hit_c;
      id_q  <= id_c;
      lx_q  <= lx_c;
      ly_q  <= ly_c;
      col_q <= col_c;
    end
  end

  assign bus.obj_hit   = hit_q;
  assign bus.obj_id    = id_q;
  assign bus.obj_lx    = lx_q;
  assign bus.obj_ly    = ly_q;
  assign bus.obj_color = col_q;
  assign bus.busy      = busy_q;
  assign bus.bounce    = bounce_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_bounce_motion_engine.sv
// tb_bounce_motion_engine: directed + randomized bench for the bouncing
// sprite engine with a two-object configuration on a 640x480 display.
module tb_bounce_motion_engine;
  import bounce_pkg::*;

  localparam int N    = 2;
  localparam int SZ   = 128;
  localparam int W    = 640;
  localparam int H    = 480;
  localparam int STEP = 1;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  fsm_state_t dbg_state;

  always #5 clk = ~clk;

  bounce_motion_engine_if #(.NUM_OBJ(N), .OBJ_SIZE(SZ), .COORD_W(COORD_W)) bus ();

  bounce_motion_engine #(
    .NUM_OBJ  (N),
    .OBJ_SIZE (SZ),
    .DISP_W   (W),
    .DISP_H   (H),
    .STEP     (STEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  int m_left [N];
  int m_top  [N];
  int m_dx   [N];
  int m_dy   [N];
  int m_col  [N];
  int exp_b  [N];
  int e_hit, e_id, e_lx, e_ly, e_col;

  int n_vec = 0;
  int n_err = 0;
  int frame_no = 0;
  int b0_count = 0;
  int b0_frame = -1;
  int o_hit, o_id, o_lx, o_ly, o_col;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_left[i] = (200 + 37 * i) % (W - SZ);
      m_top[i]  = (200 + 53 * i) % (H - SZ);
      m_dx[i]   = 1;
      m_dy[i]   = i % 2;
      m_col[i]  = i % 8;
    end
  endtask

  task automatic model_frame();
    for (int i = 0; i < N; i++) begin
      int hit_wall;
      hit_wall = 0;
      if (m_dx[i] == 0) begin
        if (m_left[i] <= STEP) begin m_left[i] = 0; m_dx[i] = 1; hit_wall = 1; end
        else m_left[i] = m_left[i] - STEP;
      end else begin
        if (m_left[i] + STEP >= W - SZ) begin m_left[i] = W - SZ; m_dx[i] = 0; hit_wall = 1; end
        else m_left[i] = m_left[i] + STEP;
      end
      if (m_dy[i] == 0) begin
        if (m_top[i] <= STEP) begin m_top[i] = 0; m_dy[i] = 1; hit_wall = 1; end
        else m_top[i] = m_top[i] - STEP;
      end else begin
        if (m_top[i] + STEP >= H - SZ) begin m_top[i] = H - SZ; m_dy[i] = 0; hit_wall = 1; end
        else m_top[i] = m_top[i] + STEP;
      end
      if (hit_wall != 0) m_col[i] = (m_col[i] + 1) % 8;
      exp_b[i] = hit_wall;
    end
  endtask

  task automatic model_pixel(input int x, input int y);
    e_hit = 0; e_id = 0; e_lx = 0; e_ly = 0; e_col = 0;
    for (int i = 0; i < N; i++) begin
      if (e_hit == 0 && x >= m_left[i] && x < m_left[i] + SZ &&
          y >= m_top[i] && y < m_top[i] + SZ) begin
        e_hit = 1; e_id = i; e_lx = x - m_left[i]; e_ly = y - m_top[i]; e_col = m_col[i];
      end
    end
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic probe(input int x, input int y);
    @(negedge clk);
    bus.pix_x = COORD_W'(x);
    bus.pix_y = COORD_W'(y);
    @(posedge clk);
    #1;
    o_hit = int'(bus.obj_hit);
    o_id  = int'(bus.obj_id);
    o_lx  = int'(bus.obj_lx);
    o_ly  = int'(bus.obj_ly);
    o_col = int'(bus.obj_color);
    model_pixel(x, y);
    chk("pix_hit",   o_hit, e_hit);
    chk("pix_id",    o_id,  e_id);
    chk("pix_lx",    o_lx,  e_lx);
    chk("pix_ly",    o_ly,  e_ly);
    chk("pix_color", o_col, e_col);
  endtask

  task automatic probe_random();
    probe(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)));
  endtask

  // Pulse frame_start (held two cycles when hold2 is set, so the second
  // request lands while the sweep is already running) and watch the sweep.
  task automatic run_frame(input bit hold2);
    int busy_cnt;
    int bc [N];
    busy_cnt = 0;
    for (int j = 0; j < N; j++) bc[j] = 0;
    @(negedge clk);
    bus.frame_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k == (hold2 ? 1 : 0)) bus.frame_start = 1'b0;
      busy_cnt += int'(bus.busy);
      for (int j = 0; j < N; j++) bc[j] += int'(bus.bounce[j]);
    end
    if (bus.pause) begin
      for (int j = 0; j < N; j++) exp_b[j] = 0;
      chk("busy_cycles_paused", busy_cnt, 0);
    end else begin
      model_frame();
      frame_no++;
      chk("busy_cycles", busy_cnt, N);
    end
    for (int j = 0; j < N; j++) chk($sformatf("bounce%0d", j), bc[j], exp_b[j]);
    if (bc[0] > 0) begin
      b0_count += bc[0];
      b0_frame  = frame_no;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.frame_start = 1'b0;
    bus.pause       = 1'b0;
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    reset           = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit",    int'(bus.obj_hit),   0);
    chk("rst_id",     int'(bus.obj_id),    0);
    chk("rst_lx",     int'(bus.obj_lx),    0);
    chk("rst_ly",     int'(bus.obj_ly),    0);
    chk("rst_color",  int'(bus.obj_color), 0);
    chk("rst_busy",   int'(bus.busy),      0);
    chk("rst_bounce", int'(bus.bounce),    0);
    chk("rst_state",  int'(dbg_state),     int'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Reset positions and colours via corner probes.
    probe(200, 200);
    chk("obj0_corner_id", o_id, 0); chk("obj0_corner_lx", o_lx, 0); chk("obj0_corner_col", o_col, 0);
    probe(364, 380);
    chk("obj1_corner_hit", o_hit, 1); chk("obj1_corner_id", o_id, 1);
    chk("obj1_corner_lx", o_lx, 127); chk("obj1_corner_col", o_col, 1);

    probe(240, 260);
    chk("px240_hit", o_hit, 1); chk("px240_id", o_id, 0);
    chk("px240_lx", o_lx, 40); chk("px240_ly", o_ly, 60);
    probe(330, 300);
    chk("px330_id", o_id, 1); chk("px330_lx", o_lx, 93); chk("px330_ly", o_ly, 47);
    probe(100, 100);
    chk("px100_hit", o_hit, 0);
    probe(327, 252);
    probe(328, 200);
    probe(199, 327);
    for (int r = 0; r < 20; r++) probe_random();

    // 200 frames: obj0 reaches the top wall on the last one.
    for (int f = 0; f < 200; f++) begin
      run_frame(1'b0);
      if (f % 25 == 0) probe_random();
    end
    probe(400, 0);
    chk("f200_hit", o_hit, 1); chk("f200_id", o_id, 0);
    chk("f200_lx", o_lx, 0); chk("f200_ly", o_ly, 0); chk("f200_color", o_col, 1);
    chk("f200_bounce0_count", b0_count, 1);
    chk("f200_bounce0_frame", b0_frame, 200);

    // Paused: requests dropped, nothing moves.
    bus.pause = 1'b1;
    for (int f = 0; f < 5; f++) run_frame(1'b0);
    bus.pause = 1'b0;
    probe(400, 0);
    chk("pause_lx", o_lx, 0); chk("pause_ly", o_ly, 0);

    // Second request during a sweep is dropped: one move only.
    run_frame(1'b1);
    probe(401, 1);
    chk("dbl_hit", o_hit, 1); chk("dbl_lx", o_lx, 0); chk("dbl_ly", o_ly, 0);

    // Reset in the middle of a sweep.
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    chk("mid_busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_busy_after",   int'(bus.busy),   0);
    chk("mid_bounce_after", int'(bus.bounce), 0);
    chk("mid_hit_after",    int'(bus.obj_hit), 0);
    chk("mid_state_after",  int'(dbg_state),  int'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    probe(240, 260);
    chk("mid_px_lx", o_lx, 40); chk("mid_px_ly", o_ly, 60);
    probe(330, 300);

    // Randomized frames, pause and double requests.
    for (int r = 0; r < 60; r++) begin
      bus.pause = ($urandom_range(0, 3) == 0);
      run_frame(1'($urandom_range(0, 1)));
      probe_random();
    end
    bus.pause = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
